// File: rtl/fw_scan_reader_pkg.sv
// Shared definitions for the FW scan-out reader.
//   - state_e      : reader FSM states
//   - ST_*         : bit positions inside fw_read_status32
//   - WORD_W       : FIFO word width (bits)
//   - sat8()       : saturate a count into an 8-bit status field
package fw_scan_reader_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_SHIFT_LO = 3'd2,
        S_SHIFT_HI = 3'd3,
        S_FLUSH    = 3'd4,
        S_DONE     = 3'd5
    } state_e;

    localparam int ST_BUSY       = 0;
    localparam int ST_DONE       = 1;
    localparam int ST_FIFO_EMPTY = 2;
    localparam int ST_FIFO_FULL  = 3;
    localparam int ST_OVERFLOW   = 4;
    localparam int ST_UNDERFLOW  = 5;
    localparam int ST_BAD_LEN    = 6;
    localparam int ST_EXEC_BUSY  = 7;
    localparam int ST_WCNT_LSB   = 8;
    localparam int ST_BITS_LSB   = 16;

    function automatic logic [7:0] sat8(input logic [31:0] v);
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/fw_sync_fifo32.sv
// Single-clock 32-bit FIFO with a registered head word.
//   clk_i        : clock
//   rst_ni       : synchronous active-low reset
//   flush_i      : synchronous flush (same effect as reset)
//   push_i       : write push_data_i (accepted if not full, or if popping)
//   push_data_i  : word to write
//   pop_i        : discard head word (ignored when empty)
//   full_o/empty_o/count_o : occupancy
//   head_o       : registered head word, 0 when empty
// DEPTH must be a power of 2 and at least 2.
module fw_sync_fifo32 #(
    parameter int DEPTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    input  logic                      push_i,
    input  logic [31:0]               push_data_i,
    input  logic                      pop_i,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic [31:0]               head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   head_q, head_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
        do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        // Head is the word at the next read pointer; bypass when that slot is
        // being written this very cycle.
        if (count_d == '0) begin
            head_d = '0;
        end else if (do_push && (wr_ptr_q == rd_ptr_d)) begin
            head_d = push_data_i;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = head_q;

endmodule

// File: rtl/fw_scan_out_reader.sv
// FW-side scan-chain reader. On execute it strobes fw_scan_load, then clocks
// the DUT chain with fw_scan_clk and packs fw_scan_out LSB-first into 32-bit
// words stored in a FIFO that SW drains one word per r_data_array_0 op.
//   fw_clk, fw_rst_n            : clock, synchronous active-low reset
//   fw_dev_id_enable            : qualifies all op codes
//   fw_op_code_w_reset          : abort + flush + clear (highest priority)
//   fw_op_code_w_execute        : start readback of sw_write24_0[NBITS_W-1:0] bits
//   fw_op_code_w_status_clear   : clear sticky flags
//   fw_op_code_r_data_array_0   : pop one FIFO word
//   fw_scan_out                 : serial data from DUT chain
//   fw_scan_load, fw_scan_clk   : DUT chain capture strobe / shift clock
//   fw_read_data32              : FIFO head word (0 when empty)
//   fw_read_status32            : status word
module fw_scan_out_reader
    import fw_scan_reader_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int DEPTH   = 32,
    parameter int NBITS_W = 16
) (
    input  logic        fw_clk,
    input  logic        fw_rst_n,
    input  logic        fw_dev_id_enable,
    input  logic        fw_op_code_w_reset,
    input  logic        fw_op_code_w_execute,
    input  logic        fw_op_code_w_status_clear,
    input  logic        fw_op_code_r_data_array_0,
    input  logic [23:0] sw_write24_0,
    input  logic        fw_scan_out,
    output logic        fw_scan_load,
    output logic        fw_scan_clk,
    output logic [31:0] fw_read_data32,
    output logic [31:0] fw_read_status32
);

    localparam int MAX_BITS = DEPTH * WORD_W;
    localparam int CNT_W    = $clog2(DEPTH) + 1;
    localparam int DIV_W    = $clog2(2 * CLK_DIV);
    localparam logic [DIV_W-1:0] LOAD_LAST  = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0] PHASE_LAST = DIV_W'(CLK_DIV - 1);

    logic               op_reset, op_exec, op_clr, op_pop;
    logic [NBITS_W-1:0] n_in;
    logic               len_ok;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [NBITS_W-1:0] bit_q, bit_d;
    logic [NBITS_W-1:0] n_q, n_d;
    logic [31:0]        shift_q, shift_d;
    logic               push_req;
    logic [31:0]        push_word;

    logic done_q, done_d, ovf_q, ovf_d, unf_q, unf_d;
    logic bad_len_q, bad_len_d, exec_busy_q, exec_busy_d;
    logic scan_load_q, scan_clk_q;
    logic [31:0] status_q, status_d;

    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [31:0]      fifo_head;

    assign op_reset = fw_dev_id_enable && fw_op_code_w_reset;
    assign op_exec  = fw_dev_id_enable && fw_op_code_w_execute && !op_reset;
    assign op_clr   = fw_dev_id_enable && fw_op_code_w_status_clear && !op_reset;
    assign op_pop   = fw_dev_id_enable && fw_op_code_r_data_array_0 && !op_reset;

    assign n_in   = sw_write24_0[NBITS_W-1:0];
    assign len_ok = (n_in != '0) && (32'(n_in) <= 32'(MAX_BITS));

    // Length field narrower than the SW write bus: upper bits carry no meaning.
    generate
        if (NBITS_W < 24) begin : g_unused_len
            logic unused_len_hi;
            assign unused_len_hi = ^sw_write24_0[23:NBITS_W];
        end
    endgenerate

    // Sequencer: LOAD strobe, then alternate low/high clock phases. The bit
    // is sampled at the end of each low phase, so the first bit is taken
    // before any rising edge and N bits need only N-1 rising edges.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q + DIV_W'(1);
        bit_d     = bit_q;
        n_d       = n_q;
        shift_d   = shift_q;
        push_req  = 1'b0;
        push_word = shift_q;
        case (state_q)
            S_IDLE: begin
                div_d = '0;
                if (op_exec && len_ok) begin
                    n_d     = n_in;
                    bit_d   = '0;
                    shift_d = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (div_q == LOAD_LAST) begin
                    div_d   = '0;
                    state_d = S_SHIFT_LO;
                end
            end
            S_SHIFT_LO: begin
                if (div_q == PHASE_LAST) begin
                    div_d                 = '0;
                    shift_d[bit_q[4:0]]   = fw_scan_out;
                    bit_d                 = bit_q + NBITS_W'(1);
                    if (bit_q[4:0] == 5'd31) begin
                        push_req  = 1'b1;
                        push_word = shift_d;
                        shift_d   = '0;
                    end
                    state_d = (bit_d == n_q) ? S_FLUSH : S_SHIFT_HI;
                end
            end
            S_SHIFT_HI: begin
                if (div_q == PHASE_LAST) begin
                    div_d   = '0;
                    state_d = S_SHIFT_LO;
                end
            end
            S_FLUSH: begin
                div_d    = '0;
                // Upper bits of the partial word are already 0 (cleared on each push).
                push_req = (n_q[4:0] != 5'd0);
                state_d  = S_DONE;
            end
            S_DONE: begin
                div_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                div_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Sticky flags; status clear beats any set in the same cycle.
    always_comb begin
        done_d      = done_q || (state_q == S_DONE);
        ovf_d       = ovf_q || (push_req && fifo_full && !op_pop);
        unf_d       = unf_q || (op_pop && fifo_empty);
        bad_len_d   = bad_len_q || (op_exec && (state_q == S_IDLE) && !len_ok);
        exec_busy_d = exec_busy_q || (op_exec && (state_q != S_IDLE));
        if (op_clr) begin
            done_d      = 1'b0;
            ovf_d       = 1'b0;
            unf_d       = 1'b0;
            bad_len_d   = 1'b0;
            exec_busy_d = 1'b0;
        end
    end

    always_comb begin
        status_d                          = '0;
        status_d[ST_BUSY]                 = (state_q != S_IDLE);
        status_d[ST_DONE]                 = done_q;
        status_d[ST_FIFO_EMPTY]           = fifo_empty;
        status_d[ST_FIFO_FULL]            = fifo_full;
        status_d[ST_OVERFLOW]             = ovf_q;
        status_d[ST_UNDERFLOW]            = unf_q;
        status_d[ST_BAD_LEN]              = bad_len_q;
        status_d[ST_EXEC_BUSY]            = exec_busy_q;
        status_d[ST_WCNT_LSB +: 8]        = sat8(32'(fifo_count));
        status_d[ST_BITS_LSB +: 16]       = 16'(bit_q);
    end

    always_ff @(posedge fw_clk) begin
        if (!fw_rst_n || op_reset) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            n_q         <= '0;
            shift_q     <= '0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            bad_len_q   <= 1'b0;
            exec_busy_q <= 1'b0;
            scan_load_q <= 1'b0;
            scan_clk_q  <= 1'b0;
            status_q    <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            n_q         <= n_d;
            shift_q     <= shift_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            bad_len_q   <= bad_len_d;
            exec_busy_q <= exec_busy_d;
            // Decoded from next state so the pins track the state register exactly.
            scan_load_q <= (state_d == S_LOAD);
            scan_clk_q  <= (state_d == S_SHIFT_HI);
            status_q    <= status_d;
        end
    end

    fw_sync_fifo32 #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (fw_clk),
        .rst_ni      (fw_rst_n),
        .flush_i     (op_reset),
        .push_i      (push_req),
        .push_data_i (push_word),
        .pop_i       (op_pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .head_o      (fifo_head)
    );

    assign fw_scan_load     = scan_load_q;
    assign fw_scan_clk      = scan_clk_q;
    assign fw_read_data32   = fifo_head;
    assign fw_read_status32 = status_q;

endmodule

// File: tb/tb_fw_scan_out_reader.sv
module tb_fw_scan_out_reader;

    localparam int CLK_DIV = 2;
    localparam int DEPTH   = 32;
    localparam int NBITS_W = 16;
    localparam int MAXB    = DEPTH * 32;

    localparam int OP_RST = 0, OP_EXEC = 1, OP_CLR = 2, OP_POP = 3;

    logic        fw_clk = 1'b0;
    logic        fw_rst_n = 1'b0;
    logic        en = 1'b0, op_rst = 1'b0, op_exec = 1'b0, op_clr = 1'b0, op_pop = 1'b0;
    logic [23:0] n_w = '0;
    logic        fw_scan_out;
    logic        fw_scan_load, fw_scan_clk;
    logic [31:0] fw_read_data32, fw_read_status32;

    always #5 fw_clk = ~fw_clk;

    fw_scan_out_reader #(
        .CLK_DIV (CLK_DIV),
        .DEPTH   (DEPTH),
        .NBITS_W (NBITS_W)
    ) dut (
        .fw_clk                    (fw_clk),
        .fw_rst_n                  (fw_rst_n),
        .fw_dev_id_enable          (en),
        .fw_op_code_w_reset        (op_rst),
        .fw_op_code_w_execute      (op_exec),
        .fw_op_code_w_status_clear (op_clr),
        .fw_op_code_r_data_array_0 (op_pop),
        .sw_write24_0              (n_w),
        .fw_scan_out               (fw_scan_out),
        .fw_scan_load              (fw_scan_load),
        .fw_scan_clk               (fw_scan_clk),
        .fw_read_data32            (fw_read_data32),
        .fw_read_status32          (fw_read_status32)
    );

    // ---------------- DUT scan chain model ----------------
    bit pat [4096];
    int chain_idx = 0;
    int edge_cnt = 0;
    int load_cycles = 0;
    logic clk_prev = 1'b0, load_prev = 1'b0;

    assign fw_scan_out = pat[chain_idx[11:0]];

    // Load restarts the chain at bit 0; every rising scan clock advances it.
    always @(posedge fw_clk) begin
        if (fw_scan_load) begin
            chain_idx   <= 0;
            edge_cnt    <= 0;
            load_cycles <= load_prev ? load_cycles + 1 : 1;
        end else if (fw_scan_clk && !clk_prev) begin
            chain_idx <= chain_idx + 1;
            edge_cnt  <= edge_cnt + 1;
        end
        clk_prev  <= fw_scan_clk;
        load_prev <= fw_scan_load;
    end

    // ---------------- reference model + scoreboard ----------------
    logic [31:0] model_q[$];
    logic [31:0] exp_q[$];
    bit m_done, m_ovf, m_unf, m_bad, m_eb;
    int m_bits;
    int checks = 0, errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // Words a run of n bits should deliver, appended to the model FIFO.
    task automatic model_run(input int n);
        logic [31:0] word;
        for (int w = 0; w * 32 < n; w++) begin
            word = '0;
            for (int b = 0; b < 32; b++)
                if (w * 32 + b < n) word[b] = pat[w * 32 + b];
            if (model_q.size() < DEPTH) model_q.push_back(word);
            else m_ovf = 1'b1;
        end
        m_done = 1'b1;
        m_bits = n;
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        int sz;
        sz = model_q.size();
        s = '0;
        s[1] = m_done;
        s[2] = (sz == 0);
        s[3] = (sz == DEPTH);
        s[4] = m_ovf;
        s[5] = m_unf;
        s[6] = m_bad;
        s[7] = m_eb;
        s[15:8] = (sz > 255) ? 8'd255 : 8'(sz);
        s[31:16] = 16'(m_bits);
        return s;
    endfunction

    task automatic clear_model_flags();
        m_done = 0; m_ovf = 0; m_unf = 0; m_bad = 0; m_eb = 0;
    endtask

    always @(negedge fw_clk) begin
        if (fw_rst_n && en && op_pop && !op_rst) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_data: got 0x%08h with no expectation queued", fw_read_data32);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (fw_read_data32 !== e) begin
                    errors++;
                    $display("FAIL pop_data: got 0x%08h expected 0x%08h", fw_read_data32, e);
                end else begin
                    $display("ok   pop_data: 0x%08h", fw_read_data32);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic op(input int kind, input int n);
        @(posedge fw_clk); #1;
        en = 1'b1;
        n_w = 24'(n);
        case (kind)
            OP_RST:  op_rst  = 1'b1;
            OP_EXEC: op_exec = 1'b1;
            OP_CLR:  op_clr  = 1'b1;
            default: op_pop  = 1'b1;
        endcase
        @(posedge fw_clk); #1;
        en = 1'b0; op_rst = 1'b0; op_exec = 1'b0; op_clr = 1'b0; op_pop = 1'b0;
    endtask

    task automatic do_pop();
        logic [31:0] e;
        if (model_q.size() > 0) e = model_q.pop_front();
        else begin e = '0; m_unf = 1'b1; end
        exp_q.push_back(e);
        op(OP_POP, 0);
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        repeat (4) @(negedge fw_clk);
        while (fw_read_status32[0] && t < 20000) begin
            @(negedge fw_clk);
            t++;
        end
        if (t >= 20000) begin
            checks++; errors++;
            $display("FAIL %s: busy still 1 after %0d cycles, required 0", name, t);
        end
        repeat (3) @(negedge fw_clk);
    endtask

    task automatic wait_edges(input int n);
        int t;
        t = 0;
        while (edge_cnt < n && t < 2000) begin
            @(negedge fw_clk);
            t++;
        end
        if (t >= 2000) begin
            checks++; errors++;
            $display("FAIL wait_edges: edge count %0d, required %0d", edge_cnt, n);
        end
    endtask

    task automatic randomize_pat();
        for (int i = 0; i < 4096; i++) pat[i] = bit'($urandom_range(0, 1));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] a5;
        logic [31:0] c3;
        bit saw;
        int lens [2];

        m_bits = 0;
        clear_model_flags();

        // Reset state
        repeat (3) @(posedge fw_clk);
        @(negedge fw_clk);
        check("rst_scan_load", 32'(fw_scan_load), 32'd0);
        check("rst_scan_clk", 32'(fw_scan_clk), 32'd0);
        check("rst_data", fw_read_data32, 32'd0);
        check("rst_status", fw_read_status32, 32'd0);
        @(posedge fw_clk); #1 fw_rst_n = 1'b1;
        repeat (2) @(negedge fw_clk);
        check("idle_status", fw_read_status32, exp_status());

        // N=40 with A5A5A5A5 then C3, bits beyond 40 set to catch over-reads
        a5 = 32'hA5A5_A5A5;
        c3 = 32'h0000_00C3;
        for (int i = 0; i < 4096; i++) pat[i] = 1'b1;
        for (int i = 0; i < 32; i++) pat[i] = a5[i];
        for (int i = 0; i < 8; i++) pat[32 + i] = c3[i];
        op(OP_EXEC, 40);
        model_run(40);
        wait_idle("run40");
        check("run40_load_cycles", 32'(load_cycles), 32'(2 * CLK_DIV));
        check("run40_rise_edges", 32'(edge_cnt), 32'd39);
        check("run40_status", fw_read_status32, exp_status());

        // Drain plus one extra pop -> underflow, then clear
        repeat (3) do_pop();
        repeat (2) @(negedge fw_clk);
        check("underflow_status", fw_read_status32, exp_status());
        op(OP_CLR, 0);
        clear_model_flags();
        repeat (2) @(negedge fw_clk);
        check("cleared_status", fw_read_status32, exp_status());

        // Illegal lengths: nothing starts
        lens[0] = 0;
        lens[1] = MAXB + 1;
        foreach (lens[i]) begin
            op(OP_EXEC, lens[i]);
            saw = 1'b0;
            repeat (12) begin
                @(negedge fw_clk);
                saw |= fw_read_status32[0] | fw_scan_clk | fw_scan_load;
            end
            m_bad = 1'b1;
            check($sformatf("badlen_%0d_activity", lens[i]), 32'(saw), 32'd0);
            check($sformatf("badlen_%0d_status", lens[i]), fw_read_status32, exp_status());
            op(OP_CLR, 0);
            clear_model_flags();
        end

        // Two full-size runs without draining: second run overflows
        randomize_pat();
        op(OP_EXEC, MAXB);
        model_run(MAXB);
        wait_idle("full_run1");
        check("full_run1_status", fw_read_status32, exp_status());
        randomize_pat();
        op(OP_EXEC, MAXB);
        model_run(MAXB);
        wait_idle("full_run2");
        check("overflow_status", fw_read_status32, exp_status());
        repeat (DEPTH) do_pop();
        op(OP_CLR, 0);
        clear_model_flags();
        repeat (2) @(negedge fw_clk);
        check("drained_status", fw_read_status32, exp_status());

        // One partial word in FIFO, then abort an N=100 run with w_reset
        randomize_pat();
        op(OP_EXEC, 20);
        model_run(20);
        wait_idle("run20");
        check("pre_abort_head", fw_read_data32, model_q[0]);
        randomize_pat();
        op(OP_EXEC, 100);
        repeat (6) @(negedge fw_clk);
        wait_edges(3);
        op(OP_EXEC, 5);
        m_eb = 1'b1;
        repeat (2) @(negedge fw_clk);
        check("exec_busy_flag", 32'(fw_read_status32[7:7]), 32'd1);
        check("busy_flag_midrun", 32'(fw_read_status32[0:0]), 32'd1);
        wait_edges(10);
        op(OP_RST, 0);
        @(negedge fw_clk);
        check("abort_scan_load", 32'(fw_scan_load), 32'd0);
        check("abort_scan_clk", 32'(fw_scan_clk), 32'd0);
        check("abort_data", fw_read_data32, 32'd0);
        check("abort_status", fw_read_status32, 32'd0);
        model_q.delete();
        clear_model_flags();
        m_bits = 0;
        repeat (2) @(negedge fw_clk);
        check("post_abort_status", fw_read_status32, exp_status());

        // FIFO holds one word; pop coincides with the first push of an N=64 run
        randomize_pat();
        op(OP_EXEC, 32);
        model_run(32);
        wait_idle("run32");
        randomize_pat();
        op(OP_EXEC, 64);
        model_run(64);
        // Bit 31 is sampled 2*CLK_DIV + CLK_DIV + 31*2*CLK_DIV cycles after execute.
        repeat (3 * CLK_DIV + 31 * 2 * CLK_DIV - 2) @(posedge fw_clk);
        do_pop();
        @(negedge fw_clk);
        check("coincide_head", fw_read_data32, model_q[0]);
        repeat (2) @(negedge fw_clk);
        check("coincide_count", 32'(fw_read_status32[15:8]), 32'd1);
        wait_idle("run64");
        check("run64_status", fw_read_status32, exp_status());
        repeat (2) do_pop();
        repeat (2) @(negedge fw_clk);
        check("final_status", fw_read_status32, exp_status());
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
